// File: rtl/cr16_datapath_pipe.sv
// cr16_datapath_pipe: pipelined CR16 register file and ALU with a registered result stage and one-level bypass.
// Define CR16_DATAPATH_MUL_EN to make opcode 9 a two-cycle multiply; otherwise opcode 9 is a NOP.
module cr16_datapath_pipe #(
    parameter  int WIDTH    = 16,
    parameter  int NUM_REGS = 16,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [3:0]       I_OPCODE,
    input  logic [SEL_W-1:0] I_SEL_A,
    input  logic [SEL_W-1:0] I_SEL_B,
    input  logic             I_USE_IMM,
    input  logic [WIDTH-1:0] I_IMM,
    input  logic             I_WRITE_EN,
    output logic [WIDTH-1:0] O_RESULT,
    output logic             O_RESULT_VALID,
    output logic [4:0]       O_FLAGS,
    input  logic [SEL_W-1:0] I_DBG_SEL,
    output logic [WIDTH-1:0] O_DBG_DATA
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_CMP  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_MOV  = 4'd7,
        OP_LSH  = 4'd8,
        OP_MUL  = 4'd9
    } opcode_e;

    localparam int MSB = WIDTH - 1;
    localparam int F_C = 4;
    localparam int F_L = 3;
    localparam int F_F = 2;
    localparam int F_Z = 1;
    localparam int F_N = 0;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic             wb_valid;
    logic             wb_we;
    logic [SEL_W-1:0] wb_dst;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       alu_flags;
    logic             alu_wr;
    logic [WIDTH:0]   sum;
    logic [4:0]       sh_amt;
    logic [4:0]       sh_mag;
    logic             accept;
    logic             is_mul;

`ifdef CR16_DATAPATH_MUL_EN
    logic             mul_busy;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_res;
    logic             mul_wr;
    logic [SEL_W-1:0] mul_dst;

    assign is_mul  = (I_OPCODE == OP_MUL);
    assign O_READY = !mul_busy;
    assign mul_res = mul_a * mul_b;
`else
    assign is_mul  = 1'b0;
    assign O_READY = 1'b1;
`endif

    assign accept = I_VALID && O_READY;

    // The WB-stage result overrides the register file until its write lands one edge later.
    assign op_a = (wb_we && (wb_dst == I_SEL_A)) ? result_q : regs[I_SEL_A];
    assign op_b = I_USE_IMM                      ? I_IMM
                : (wb_we && (wb_dst == I_SEL_B)) ? result_q
                :                                  regs[I_SEL_B];

    assign O_RESULT       = result_q;
    assign O_RESULT_VALID = wb_valid;
    assign O_FLAGS        = flags_q;
    assign O_DBG_DATA     = regs[I_DBG_SEL];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res   = op_a;
        alu_flags = flags_q;
        alu_wr    = 1'b0;
        sum       = '0;
        sh_amt    = op_b[4:0];
        sh_mag    = sh_amt[4] ? (~sh_amt + 5'd1) : sh_amt;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                sum = {1'b0, op_a} + {1'b0, op_b}
                    + {{WIDTH{1'b0}}, (I_OPCODE == OP_ADDC) && flags_q[F_C]};
                alu_res        = sum[MSB:0];
                alu_flags[F_C] = sum[WIDTH];
                alu_flags[F_F] = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
                alu_flags[F_Z] = (alu_res == '0);
                alu_flags[F_N] = alu_res[MSB];
                alu_wr         = 1'b1;
            end
            OP_SUB: begin
                sum            = {1'b0, op_a} - {1'b0, op_b};
                alu_res        = sum[MSB:0];
                alu_flags[F_C] = (op_a < op_b);
                alu_flags[F_F] = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
                alu_flags[F_Z] = (alu_res == '0);
                alu_flags[F_N] = alu_res[MSB];
                alu_wr         = 1'b1;
            end
            OP_CMP: begin
                alu_flags[F_Z] = (op_a == op_b);
                alu_flags[F_L] = (op_a < op_b);
                alu_flags[F_N] = ($signed(op_a) < $signed(op_b));
            end
            OP_AND, OP_OR, OP_XOR: begin
                alu_res        = (I_OPCODE == OP_AND) ? (op_a & op_b)
                               : (I_OPCODE == OP_OR)  ? (op_a | op_b)
                               :                        (op_a ^ op_b);
                alu_flags[F_Z] = (alu_res == '0);
                alu_flags[F_N] = alu_res[MSB];
                alu_wr         = 1'b1;
            end
            OP_MOV: begin
                alu_res = op_b;
                alu_wr  = 1'b1;
            end
            OP_LSH: begin
                // Shift count is a signed 5-bit field: positive shifts left, negative shifts right.
                if (int'(sh_mag) >= WIDTH) begin
                    alu_res = '0;
                end else begin
                    alu_res = sh_amt[4] ? (op_a >> sh_mag) : (op_a << sh_mag);
                end
                alu_flags[F_Z] = (alu_res == '0);
                alu_wr         = 1'b1;
            end
            default: begin
                alu_res = op_a;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            result_q <= '0;
            flags_q  <= '0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_dst   <= '0;
`ifdef CR16_DATAPATH_MUL_EN
            mul_busy <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_wr   <= 1'b0;
            mul_dst  <= '0;
`endif
        end else begin
            if (wb_we) begin
                regs[wb_dst] <= result_q;
            end
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            if (accept && !is_mul) begin
                result_q <= alu_res;
                flags_q  <= alu_flags;
                wb_valid <= 1'b1;
                wb_we    <= I_WRITE_EN && alu_wr;
                wb_dst   <= I_SEL_A;
            end
`ifdef CR16_DATAPATH_MUL_EN
            mul_busy <= accept && is_mul;
            if (accept && is_mul) begin
                mul_a   <= op_a;
                mul_b   <= op_b;
                mul_wr  <= I_WRITE_EN;
                mul_dst <= I_SEL_A;
            end
            if (mul_busy) begin
                result_q       <= mul_res;
                flags_q[F_Z]   <= (mul_res == '0);
                flags_q[F_N]   <= mul_res[MSB];
                wb_valid       <= 1'b1;
                wb_we          <= mul_wr;
                wb_dst         <= mul_dst;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cr16_datapath_pipe.sv
// tb_cr16_datapath_pipe: directed plan plus randomized ops, checked every cycle against an architectural model.
// Honours CR16_DATAPATH_MUL_EN to expect either the two-cycle multiply or a NOP on opcode 9.
module tb_cr16_datapath_pipe;

    logic        clk = 1'b0;
    logic        I_RESET;
    logic        I_VALID;
    logic        O_READY;
    logic [3:0]  I_OPCODE;
    logic [3:0]  I_SEL_A;
    logic [3:0]  I_SEL_B;
    logic        I_USE_IMM;
    logic [15:0] I_IMM;
    logic        I_WRITE_EN;
    logic [15:0] O_RESULT;
    logic        O_RESULT_VALID;
    logic [4:0]  O_FLAGS;
    logic [3:0]  I_DBG_SEL;
    logic [15:0] O_DBG_DATA;

    always #5 clk = ~clk;

    cr16_datapath_pipe dut (
        .I_CLK          (clk),
        .I_RESET        (I_RESET),
        .I_VALID        (I_VALID),
        .O_READY        (O_READY),
        .I_OPCODE       (I_OPCODE),
        .I_SEL_A        (I_SEL_A),
        .I_SEL_B        (I_SEL_B),
        .I_USE_IMM      (I_USE_IMM),
        .I_IMM          (I_IMM),
        .I_WRITE_EN     (I_WRITE_EN),
        .O_RESULT       (O_RESULT),
        .O_RESULT_VALID (O_RESULT_VALID),
        .O_FLAGS        (O_FLAGS),
        .I_DBG_SEL      (I_DBG_SEL),
        .O_DBG_DATA     (O_DBG_DATA)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural model: arch holds program-order register values, vis lags by the writeback delay.
    logic [15:0] m_arch [16];
    logic [15:0] m_vis  [16];
    logic [15:0] m_result;
    logic [4:0]  m_flags;   // {C,L,F,Z,N}
    logic        m_valid;
    logic        m_busy;
    logic        m_pend_we;
    logic [3:0]  m_pend_dst;
    logic [15:0] m_pend_val;
    logic [15:0] m_mul_val;
    logic        m_mul_we;
    logic [3:0]  m_mul_dst;

    always @(posedge clk) begin : model
        int a, b, sa, sb, s, t, k, cin;
        logic [15:0] r;
        logic [4:0]  f;
        logic        wr;
        if (I_RESET) begin
            for (int i = 0; i < 16; i++) begin
                m_arch[i] = 16'h0;
                m_vis[i]  = 16'h0;
            end
            m_result  = 16'h0;
            m_flags   = 5'h0;
            m_valid   = 1'b0;
            m_busy    = 1'b0;
            m_pend_we = 1'b0;
        end else begin
            if (m_pend_we) m_vis[m_pend_dst] = m_pend_val;
            m_pend_we = 1'b0;
            if (m_busy) begin
                m_busy     = 1'b0;
                m_result   = m_mul_val;
                m_flags[1] = (m_mul_val == 16'h0);
                m_flags[0] = m_mul_val[15];
                m_valid    = 1'b1;
                m_pend_we  = m_mul_we;
                m_pend_dst = m_mul_dst;
                m_pend_val = m_mul_val;
            end else if (I_VALID) begin
                a   = int'(m_arch[I_SEL_A]);
                b   = I_USE_IMM ? int'(I_IMM) : int'(m_arch[I_SEL_B]);
                sa  = (a >= 32768) ? a - 65536 : a;
                sb  = (b >= 32768) ? b - 65536 : b;
                f   = m_flags;
                r   = 16'(a);
                wr  = 1'b0;
                cin = 0;
                m_valid = 1'b1;
                case (int'(I_OPCODE))
                    0, 1: begin
                        if (I_OPCODE == 4'd1) cin = int'(m_flags[4]);
                        s = a + b + cin;
                        t = sa + sb + cin;
                        r = 16'(s);
                        f[4] = (s > 65535);
                        f[2] = (t > 32767) || (t < -32768);
                        f[1] = (r == 16'h0);
                        f[0] = r[15];
                        wr = 1'b1;
                    end
                    2: begin
                        s = a - b;
                        t = sa - sb;
                        r = 16'(s);
                        f[4] = (a < b);
                        f[2] = (t > 32767) || (t < -32768);
                        f[1] = (r == 16'h0);
                        f[0] = r[15];
                        wr = 1'b1;
                    end
                    3: begin
                        f[1] = (a == b);
                        f[3] = (a < b);
                        f[0] = (sa < sb);
                    end
                    4, 5, 6: begin
                        if (I_OPCODE == 4'd4)      r = 16'(a & b);
                        else if (I_OPCODE == 4'd5) r = 16'(a | b);
                        else                       r = 16'(a ^ b);
                        f[1] = (r == 16'h0);
                        f[0] = r[15];
                        wr = 1'b1;
                    end
                    7: begin
                        r  = 16'(b);
                        wr = 1'b1;
                    end
                    8: begin
                        k = b % 32;
                        if (k >= 16) k = k - 32;
                        if (k >= 16 || k <= -16) r = 16'h0;
                        else if (k >= 0)         r = 16'(a << k);
                        else                     r = 16'(a >> (-k));
                        f[1] = (r == 16'h0);
                        wr = 1'b1;
                    end
`ifdef CR16_DATAPATH_MUL_EN
                    9: begin
                        m_mul_val = 16'(a * b);
                        m_mul_we  = I_WRITE_EN;
                        m_mul_dst = I_SEL_A;
                        m_busy    = 1'b1;
                        m_valid   = 1'b0;
                        r         = m_result;
                        if (I_WRITE_EN) m_arch[I_SEL_A] = m_mul_val;
                    end
`endif
                    default: r = 16'(a);
                endcase
                if (!m_busy) begin
                    m_result = r;
                    m_flags  = f;
                    if (wr && I_WRITE_EN) begin
                        m_arch[I_SEL_A] = r;
                        m_pend_we  = 1'b1;
                        m_pend_dst = I_SEL_A;
                        m_pend_val = r;
                    end
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("result_valid", O_RESULT_VALID, m_valid);
            check("result", O_RESULT, m_result);
            check("flags", O_FLAGS, m_flags);
            check("ready", O_READY, !m_busy);
            check("dbg_data", O_DBG_DATA, m_vis[I_DBG_SEL]);
        end
    end

    task automatic cyc(input logic [3:0] op, input logic [3:0] sel_a, input logic [3:0] sel_b,
                       input logic use_imm, input logic [15:0] imm, input logic we);
        I_RESET    = 1'b0;
        I_VALID    = 1'b1;
        I_OPCODE   = op;
        I_SEL_A    = sel_a;
        I_SEL_B    = sel_b;
        I_USE_IMM  = use_imm;
        I_IMM      = imm;
        I_WRITE_EN = we;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [3:0] sel, input logic [15:0] exp, input string name);
        I_RESET   = 1'b0;
        I_VALID   = 1'b0;
        I_DBG_SEL = sel;
        @(posedge clk);
        #1;
        check(name, O_DBG_DATA, exp);
    endtask

    task automatic do_reset();
        I_RESET = 1'b1;
        I_VALID = 1'b0;
        @(posedge clk);
        #1;
        I_RESET = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        I_RESET = 1'b1; I_VALID = 1'b0; I_OPCODE = 4'd0; I_SEL_A = 4'd0; I_SEL_B = 4'd0;
        I_USE_IMM = 1'b0; I_IMM = 16'h0; I_WRITE_EN = 1'b0; I_DBG_SEL = 4'd0;
        @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;
        check("rst_flags", O_FLAGS, 5'h00);
        check("rst_valid", O_RESULT_VALID, 1'b0);
        check("rst_ready", O_READY, 1'b1);

        // MOV imm into R3, read it back two cycles later
        cyc(4'd7, 4'd3, 4'd0, 1'b1, 16'h1234, 1'b1);
        check("mov_result", O_RESULT, 16'h1234);
        peek(4'd3, 16'h1234, "mov_r3");
        peek(4'd0, 16'h0000, "mov_r0_clear");
        peek(4'd15, 16'h0000, "mov_r15_clear");
        check("mov_flags", O_FLAGS, 5'h00);

        // ADD wraps with carry, ADDC consumes it back-to-back
        cyc(4'd7, 4'd1, 4'd0, 1'b1, 16'hFFFF, 1'b1);
        cyc(4'd7, 4'd2, 4'd0, 1'b1, 16'h0001, 1'b1);
        cyc(4'd0, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b1);
        check("add_result", O_RESULT, 16'h0000);
        check("add_flags", O_FLAGS, 5'b10010);
        cyc(4'd1, 4'd4, 4'd0, 1'b1, 16'h0000, 1'b1);
        check("addc_result", O_RESULT, 16'h0001);
        check("addc_flags", O_FLAGS, 5'b00000);
        peek(4'd1, 16'h0000, "add_r1");
        peek(4'd4, 16'h0001, "addc_r4");

        // Dependent chain through the bypass
        cyc(4'd7, 4'd5, 4'd0, 1'b1, 16'd5, 1'b1);
        check("chain0", O_RESULT, 16'd5);
        cyc(4'd0, 4'd5, 4'd0, 1'b1, 16'd3, 1'b1);
        check("chain1", O_RESULT, 16'd8);
        cyc(4'd0, 4'd5, 4'd0, 1'b1, 16'd2, 1'b1);
        check("chain2", O_RESULT, 16'd10);
        peek(4'd5, 16'd10, "chain_r5");

        // CMP, SUB overflow, LSH by -1
        cyc(4'd7, 4'd6, 4'd0, 1'b1, 16'h8000, 1'b1);
        cyc(4'd7, 4'd7, 4'd0, 1'b1, 16'h0001, 1'b1);
        cyc(4'd3, 4'd6, 4'd7, 1'b0, 16'h0000, 1'b1);
        check("cmp_result", O_RESULT, 16'h8000);
        check("cmp_flags", O_FLAGS, 5'b00001);
        cyc(4'd2, 4'd6, 4'd7, 1'b0, 16'h0000, 1'b1);
        check("sub_result", O_RESULT, 16'h7FFF);
        check("sub_flags", O_FLAGS, 5'b00100);
        cyc(4'd8, 4'd7, 4'd0, 1'b1, 16'h001F, 1'b1);
        check("lsh_result", O_RESULT, 16'h0000);
        check("lsh_flags", O_FLAGS, 5'b00110);
        peek(4'd6, 16'h7FFF, "sub_r6");
        peek(4'd7, 16'h0000, "lsh_r7");

        // NOP held valid with write enable
        for (int i = 0; i < 3; i++) begin
            cyc(4'd12, 4'd6, 4'd7, 1'b0, 16'h0000, 1'b1);
            check("nop_result", O_RESULT, 16'h7FFF);
            check("nop_flags", O_FLAGS, 5'b00110);
        end
        peek(4'd6, 16'h7FFF, "nop_r6");

        // Reset while the ADD sits in writeback
        cyc(4'd0, 4'd8, 4'd0, 1'b1, 16'd5, 1'b1);
        check("rst_add_result", O_RESULT, 16'd5);
        do_reset();
        check("rst_mid_result", O_RESULT, 16'h0000);
        peek(4'd8, 16'h0000, "rst_mid_r8");

        // Multiply followed by a dependent ADD
        cyc(4'd7, 4'd1, 4'd0, 1'b1, 16'd300, 1'b1);
        cyc(4'd7, 4'd2, 4'd0, 1'b1, 16'd300, 1'b1);
        cyc(4'd9, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b1);
`ifdef CR16_DATAPATH_MUL_EN
        check("mul_ready_low", O_READY, 1'b0);
        cyc(4'd0, 4'd1, 4'd0, 1'b1, 16'd1, 1'b1);
        check("mul_result", O_RESULT, 16'h5F90);
        check("mul_ready_high", O_READY, 1'b1);
        cyc(4'd0, 4'd1, 4'd0, 1'b1, 16'd1, 1'b1);
        check("mul_add_result", O_RESULT, 16'h5F91);
        peek(4'd1, 16'h5F91, "mul_add_r1");
`else
        check("mul_nop_result", O_RESULT, 16'd300);
        check("mul_nop_ready", O_READY, 1'b1);
        peek(4'd1, 16'd300, "mul_nop_r1");
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2500; n++) begin
            I_RESET    = ($urandom_range(0, 199) == 0);
            I_VALID    = ($urandom_range(0, 3) != 0);
            I_OPCODE   = 4'($urandom_range(0, 15));
            I_SEL_A    = 4'($urandom);
            I_SEL_B    = 4'($urandom);
            I_USE_IMM  = 1'($urandom);
            I_WRITE_EN = ($urandom_range(0, 4) != 0);
            I_DBG_SEL  = 4'($urandom);
            case ($urandom_range(0, 4))
                0:       I_IMM = 16'hFFFF;
                1:       I_IMM = 16'h8000;
                2:       I_IMM = 16'($urandom_range(0, 40));
                default: I_IMM = 16'($urandom);
            endcase
            @(posedge clk);
            #1;
        end

        I_VALID = 1'b0;
        I_RESET = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cr16_datapath_pipe.md
Name: cr16_datapath_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle CR16 datapath.
- Contains a register file, read-operand selection with one-level writeback bypass, an integrated ALU with a registered result stage, and a flag register.
- Accepts one operation per cycle over a valid/ready handshake. Sits between the control FSM/decoder and memory/IO, which consume O_RESULT.

Parameters:
- WIDTH, 16, data width of registers, operands and result; minimum 8.
- NUM_REGS, 16, number of general registers; power of two, 2..32.
- SEL_W, $clog2(NUM_REGS), local, register-select width.

Ports:
- I_CLK  in  1  clock; all state updates on rising edge.
- I_RESET  in  1  reset, synchronous, active-high.
- I_VALID  in  1  operation offered this cycle.
- O_READY  out  1  datapath can accept; the operation is accepted when I_VALID && O_READY.
- I_OPCODE  in  4  ALU operation.
- I_SEL_A  in  SEL_W  source register for operand A (also the destination).
- I_SEL_B  in  SEL_W  source register for operand B.
- I_USE_IMM  in  1  1: operand B = I_IMM instead of register.
- I_IMM  in  WIDTH  immediate operand.
- I_WRITE_EN  in  1  write result to register I_SEL_A.
- O_RESULT  out  WIDTH  registered ALU result.
- O_RESULT_VALID  out  1  O_RESULT holds a newly completed operation this cycle.
- O_FLAGS  out  5  registered flags {C,L,F,Z,N}, bit4 = C, bit0 = N.
- I_DBG_SEL  in  SEL_W  debug read select.
- O_DBG_DATA  out  WIDTH  combinational read of the register file (no bypass).

Behaviour:
- Reset:
  - Synchronous and active-high.
  - All registers, O_RESULT, O_FLAGS and O_RESULT_VALID clear to 0.
  - O_READY is 1 in the cycle after reset.
  - Reset mid-operation discards any in-flight result; no register write occurs.
- Pipeline: ISSUE → WB.
  - ISSUE (cycle t, op accepted): operands are selected and the ALU evaluates combinationally. O_RESULT, the WB destination/write-enable, and the flags are registered at edge t+1.
  - WB (cycle t+1): O_RESULT_VALID = 1. If write-enabled, register I_SEL_A(t) is written at edge t+2.
- Bypass:
  - If WB is write-enabled and its destination equals I_SEL_A or I_SEL_B (when not using the immediate), that operand takes O_RESULT instead of the register file.
  - Back-to-back dependent operations therefore see the new value with zero stalls.
  - A register read in the same cycle as its write sees the bypassed value.
- No accept: O_RESULT_VALID = 0 next cycle; O_RESULT and the flags hold.
- Operand B = I_USE_IMM ? I_IMM : reg[I_SEL_B].
- Opcodes (A = operand A, B = operand B, result truncated to WIDTH):
  - 0 ADD: A+B. Sets C = carry out, F = signed overflow, Z, N.
  - 1 ADDC: A+B+C. Uses the flag register as updated at the previous edge. Sets C, F, Z, N.
  - 2 SUB: A−B. Sets C = borrow (A<B unsigned), F = signed overflow, Z, N.
  - 3 CMP: no register write regardless of I_WRITE_EN. Sets Z = (A==B), L = (A<B unsigned), N = (A<B signed). C and F unchanged. O_RESULT_VALID still pulses; O_RESULT = A.
  - 4 AND, 5 OR, 6 XOR: set Z and N = result MSB.
  - 7 MOV: result = B; flags unchanged.
  - 8 LSH: B[4:0] is treated as signed. Positive values shift A left, negative values shift logically right. Magnitudes ≥ WIDTH give 0. Sets Z.
  - 9 MUL: see Optional Feature.
  - 10–15: NOP. Result = A, no write, flags unchanged.
- Flags not listed for an opcode hold their value.
- The flag register updates only on accepted operations.
- O_READY is constantly 1 unless MUL is in progress.

Optional Feature:
- Macro: CR16_DATAPATH_MUL_EN.
- Defined:
  - Opcode 9 computes the low WIDTH bits of A×B using a two-cycle multiplier. Sets Z and N.
  - MUL accepted at t → O_READY = 0 during t+1; the result is registered at edge t+2 (O_RESULT_VALID at t+2); O_READY = 1 at t+2.
  - Operands are captured at accept. The bypass applies to the MUL result exactly as for single-cycle ops.
  - Reset during t+1 aborts the multiply.
- Undefined: opcode 9 behaves as NOP and O_READY is tied to 1.

Test Plan:
- Reset, then MOV imm 0x1234 → R3, then debug-read R3 two cycles later → O_DBG_DATA = 0x1234; all other registers 0; O_FLAGS = 0.
- R1 = 0xFFFF, R2 = 0x0001; ADD R1,R2 then ADDC R4 (R4 = 0),imm 0 back-to-back → R1 = 0x0000 with C = 1 and Z = 1; R4 = 0x0001.
- Dependent chain: MOV R5 ← imm 5; ADD R5 += imm 3; ADD R5 += imm 2 on consecutive cycles → O_RESULT sequence 5, 8, 10 with no stall; R5 = 10.
- R6 = 0x8000, R7 = 0x0001: CMP R6,R7 → L = 0, N = 1, Z = 0, no write; then SUB R6,R7 → R6 = 0x7FFF with F = 1, C = 0. LSH R7 by imm 0x1F (−1) → 0x0000 with Z = 1.
- I_VALID held with NOP opcode 12 and I_WRITE_EN = 1 → no register changes and flags hold. Reset asserted the cycle after an accepted ADD → destination register stays 0.
- With CR16_DATAPATH_MUL_EN: R1 = 300, R2 = 300; MUL then ADD R1 += imm 1 offered immediately → O_READY low one cycle; R1 = 0x5F90 then 0x5F91. Without the macro the same MUL leaves R1 = 300.
